wb_gpio_irq: RTL
================

Name: wb_gpio_irq

Overview:
- Parametrised next-generation Wishbone GPIO peripheral.
- Adds a configurable pin count, per-pin direction, and a synchroniser on the input path.
- Adds per-pin rising/falling edge interrupt capture with W1C status and one aggregated interrupt output.
- Sits on the Wishbone pipelined slave bus next to the other peripherals. Pads are exposed as separate in/out/oe vectors; tristate resolution lives at the top level.

Parameters:
- NUM_GPIO, 32, number of pins, legal range 1..32.
- SYNC_STAGES, 2, input synchroniser flops per pin, legal range 2..4.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous reset, active-high.
- i_gpio  in  NUM_GPIO  pad inputs; asynchronous to i_clk.
- o_gpio  out  NUM_GPIO  pad output values.
- o_gpio_oe  out  NUM_GPIO  pad output enables, 1 = drive.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  32  byte address; only [5:2] decoded.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte selects.
- o_wb_ack  out  1  transfer acknowledge.
- o_wb_err  out  1  unmapped-address error.
- o_wb_stall  out  1  tied 0.
- o_wb_data  out  32  read data.
- o_irq  out  1  level interrupt, high while any enabled status bit is set.

Behaviour:
- Reset: asynchronous, active-high. All registers, o_gpio, o_gpio_oe, o_irq, o_wb_ack, o_wb_err and o_wb_data go to 0. Synchroniser flops also reset to 0.
- Register map (offset, access):
  - 0x00 IN, RO: synchronised pin values.
  - 0x04 OUT, RW: drives o_gpio.
  - 0x08 DIR, RW: drives o_gpio_oe.
  - 0x0C RISE_EN, RW.
  - 0x10 FALL_EN, RW.
  - 0x14 STATUS, RW1C.
  - Bits at or above NUM_GPIO read 0 and ignore writes.
- Bus handshake:
  - A request is i_wb_cyc & i_wb_stb. Every request is accepted (stall = 0).
  - o_wb_ack or o_wb_err pulses exactly 1 cycle after the request, for one cycle. Back-to-back requests give back-to-back acks.
  - o_wb_data is valid in the ack cycle and is 0 otherwise.
  - Mapped offsets return ack. Unmapped offsets return err, with no state change and read data 0.
  - If i_wb_cyc drops, a pending ack/err still fires. Masters ignore it.
- Writes honour i_wb_sel per byte. A write to IN acks and is ignored.
- Input path:
  - Each pin passes through a SYNC_STAGES flop chain; IN is the last stage.
  - A pad change is visible in IN after SYNC_STAGES rising edges.
  - A prev register holds IN from the previous cycle.
- Edge detect:
  - rise = IN & ~prev; fall = ~IN & prev.
  - STATUS[i] sets on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - Status sets 1 cycle after IN changes and stays set until cleared.
- Arming: edge detection is blocked until SYNC_STAGES+1 cycles after reset deassertion, counted by an arm counter. A pin held high through reset therefore never raises a spurious rising event.
- Status W1C: writing 1 clears the bit, writing 0 has no effect. If a clear and a new qualified edge hit the same bit in the same cycle, set wins and the bit stays 1.
- Enables: disabling RISE_EN/FALL_EN does not clear already-set STATUS bits.
- o_irq is registered |STATUS, so it asserts 1 cycle after a STATUS bit sets.
- Direction: o_gpio is always driven from OUT; o_gpio_oe = DIR. IN reflects the pad even for output pins (loopback readable).
- Reset mid-transaction: a pending ack is dropped and the master must retry.

Optional Feature:
- Macro: WB_GPIO_IRQ_ATOMIC_EN.
- When defined, three write-only aliases are added, each honouring i_wb_sel:
  - 0x18 OUT_SET: OUT |= wdata.
  - 0x1C OUT_CLR: OUT &= ~wdata.
  - 0x20 OUT_TGL: OUT ^= wdata.
- The aliases read as 0 and return ack.
- When undefined, 0x18-0x20 are unmapped and return err. No extra logic is present.

Test Plan:
- Reset, then read all six registers -> every read acks in 1 cycle with data 0x0. o_gpio_oe = 0, o_irq = 0.
- Write DIR = 0x0000_00FF and OUT = 0xA5A5_A5A5 with sel = 4'b0001 -> OUT reads 0x0000_00A5, o_gpio_oe = 0xFF, o_gpio[7:0] = 0xA5.
- Set RISE_EN[3] = 1, drive i_gpio[3] 0->1 -> IN[3] = 1 after 2 cycles, STATUS = 0x8 one cycle later, o_irq high the following cycle. Write STATUS = 0x8 -> STATUS = 0, o_irq low next cycle.
- Hold i_gpio[0] = 1 through reset with RISE_EN[0] enabled right after reset -> STATUS stays 0. Set FALL_EN[0], drive 1->0 -> STATUS[0] = 1. W1C in the same cycle as a new falling edge on the same pin -> bit remains 1.
- Read offset 0x24, and 0x18 with the macro undefined -> o_wb_err pulses one cycle, no ack, no state change. With the macro defined: OUT = 0xF0, SET 0x0F, CLR 0x30, TGL 0x81 -> OUT reads 0x4E.
- Issue 4 back-to-back reads with stb held -> 4 consecutive acks with o_wb_stall = 0 throughout.

Source files
------------

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone pipelined GPIO peripheral with per-pin direction,
// input synchroniser and rising/falling edge interrupt capture.
// Optional build macro WB_GPIO_IRQ_ATOMIC_EN adds OUT_SET/OUT_CLR/OUT_TGL
// write-only aliases at 0x18/0x1C/0x20; without it those offsets error.
module wb_gpio_irq #(
  parameter int NUM_GPIO    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NUM_GPIO-1:0] i_gpio,
  output logic [NUM_GPIO-1:0] o_gpio,
  output logic [NUM_GPIO-1:0] o_gpio_oe,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  input  logic                i_wb_we,
  input  logic [31:0]         i_wb_addr,
  input  logic [31:0]         i_wb_data,
  input  logic [3:0]          i_wb_sel,
  output logic                o_wb_ack,
  output logic                o_wb_err,
  output logic                o_wb_stall,
  output logic [31:0]         o_wb_data,
  output logic                o_irq
);

  localparam logic [3:0] ADDR_IN      = 4'd0;
  localparam logic [3:0] ADDR_OUT     = 4'd1;
  localparam logic [3:0] ADDR_DIR     = 4'd2;
  localparam logic [3:0] ADDR_RISE_EN = 4'd3;
  localparam logic [3:0] ADDR_FALL_EN = 4'd4;
  localparam logic [3:0] ADDR_STATUS  = 4'd5;
`ifdef WB_GPIO_IRQ_ATOMIC_EN
  localparam logic [3:0] ADDR_SET     = 4'd6;
  localparam logic [3:0] ADDR_CLR     = 4'd7;
  localparam logic [3:0] ADDR_TGL     = 4'd8;
`endif
  // Edges are ignored until the synchroniser has flushed its reset zeros.
  localparam logic [2:0] ARM_LAST     = 3'(SYNC_STAGES + 1);

  logic [NUM_GPIO-1:0] sync_r [SYNC_STAGES];
  logic [NUM_GPIO-1:0] in_s, prev_r;
  logic [NUM_GPIO-1:0] out_r, out_nxt_s, dir_r, rise_en_r, fall_en_r, status_r;
  logic [NUM_GPIO-1:0] wmask_s, wbits_s, edge_set_s, status_clr_s;
  logic [2:0]          arm_cnt_r;
  logic                armed_s;
  logic                req_s, wr_s, mapped_s;
  logic [3:0]          offset_s;
  logic [31:0]         byte_mask_s, rdata_s, rdata_r;
  logic                ack_r, err_r, irq_r;
  logic                unused_bits_s;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] zext(input logic [NUM_GPIO-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[NUM_GPIO-1:0] = v;
    return r;
  endfunction

  assign req_s        = i_wb_cyc & i_wb_stb;
  assign wr_s         = req_s & i_wb_we;
  assign offset_s     = i_wb_addr[5:2];
  assign byte_mask_s  = sel_to_mask(i_wb_sel);
  assign wmask_s      = byte_mask_s[NUM_GPIO-1:0];
  assign wbits_s      = i_wb_data[NUM_GPIO-1:0] & wmask_s;
  assign in_s         = sync_r[SYNC_STAGES-1];
  assign armed_s      = (arm_cnt_r == ARM_LAST);
  assign edge_set_s   = armed_s ? ((in_s & ~prev_r & rise_en_r) | (~in_s & prev_r & fall_en_r))
                                : '0;
  assign status_clr_s = (wr_s && (offset_s == ADDR_STATUS)) ? wbits_s : '0;
  assign unused_bits_s = ^{i_wb_addr[31:6], i_wb_addr[1:0], i_wb_data, byte_mask_s};

  // Address decode and read-data mux for the current request.
  always_comb begin
    mapped_s = 1'b0;
    rdata_s  = 32'd0;
    case (offset_s)
      ADDR_IN:      begin mapped_s = 1'b1; rdata_s = zext(in_s);      end
      ADDR_OUT:     begin mapped_s = 1'b1; rdata_s = zext(out_r);     end
      ADDR_DIR:     begin mapped_s = 1'b1; rdata_s = zext(dir_r);     end
      ADDR_RISE_EN: begin mapped_s = 1'b1; rdata_s = zext(rise_en_r); end
      ADDR_FALL_EN: begin mapped_s = 1'b1; rdata_s = zext(fall_en_r); end
      ADDR_STATUS:  begin mapped_s = 1'b1; rdata_s = zext(status_r);  end
`ifdef WB_GPIO_IRQ_ATOMIC_EN
      ADDR_SET, ADDR_CLR, ADDR_TGL: begin mapped_s = 1'b1; rdata_s = 32'd0; end
`endif
      default:      begin mapped_s = 1'b0; rdata_s = 32'd0;           end
    endcase
  end

  // Next OUT value from a direct write or one of the atomic aliases.
  always_comb begin
    out_nxt_s = out_r;
    if (wr_s) begin
      case (offset_s)
        ADDR_OUT: out_nxt_s = (out_r & ~wmask_s) | wbits_s;
`ifdef WB_GPIO_IRQ_ATOMIC_EN
        ADDR_SET: out_nxt_s = out_r | wbits_s;
        ADDR_CLR: out_nxt_s = out_r & ~wbits_s;
        ADDR_TGL: out_nxt_s = out_r ^ wbits_s;
`endif
        default:  out_nxt_s = out_r;
      endcase
    end else begin
      out_nxt_s = out_r;
    end
  end

  // Pad input synchroniser chain; the last stage is the IN register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= i_gpio;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Arm counter: saturates once the synchroniser holds real pad data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      arm_cnt_r <= 3'd0;
    end else if (!armed_s) begin
      arm_cnt_r <= arm_cnt_r + 3'd1;
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  // Control/status registers; a new edge wins over a same-cycle W1C.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_r     <= '0;
      dir_r     <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
      status_r  <= '0;
      prev_r    <= '0;
      irq_r     <= 1'b0;
    end else begin
      out_r <= out_nxt_s;
      if (wr_s && (offset_s == ADDR_DIR))     dir_r     <= (dir_r & ~wmask_s) | wbits_s;
      if (wr_s && (offset_s == ADDR_RISE_EN)) rise_en_r <= (rise_en_r & ~wmask_s) | wbits_s;
      if (wr_s && (offset_s == ADDR_FALL_EN)) fall_en_r <= (fall_en_r & ~wmask_s) | wbits_s;
      status_r <= (status_r & ~status_clr_s) | edge_set_s;
      prev_r   <= in_s;
      irq_r    <= |status_r;
    end
  end

  // Single-cycle bus response; read data is zero outside a read ack.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ack_r   <= req_s & mapped_s;
      err_r   <= req_s & ~mapped_s;
      rdata_r <= (req_s && mapped_s && !i_wb_we) ? rdata_s : 32'd0;
    end
  end

  assign o_gpio     = out_r;
  assign o_gpio_oe  = dir_r;
  assign o_irq      = irq_r;
  assign o_wb_ack   = ack_r;
  assign o_wb_err   = err_r;
  assign o_wb_data  = rdata_r;
  assign o_wb_stall = 1'b0;

endmodule
